// File: rtl/multicycle_adder_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
// Contents:
//   state_e          - controller states (idle, running digits, result held)
//   num_digits()     - number of digit steps per operation, WIDTH/DIGIT
//   cnt_width()      - digit counter width, $clog2(N+1)
package multicycle_adder_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    function automatic int unsigned num_digits(input int unsigned width,
                                               input int unsigned digit);
        return width / digit;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned width,
                                              input int unsigned digit);
        return $clog2(width / digit + 1);
    endfunction

endpackage

// File: rtl/multicycle_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells.
// Ports:
//   i_a, i_b  - DIGIT-bit addends
//   i_cin     - carry into bit 0
//   o_sum     - DIGIT-bit sum
//   o_cout    - carry out of the top bit
//   o_c_msb   - carry into the top bit (signed overflow detection)
module multicycle_adder_digit_adder #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_cin,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_cout,
    output logic             o_c_msb
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout  = w_c[DIGIT];
    assign o_c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/multicycle_adder.sv
// Digit-serial adder/subtractor: consumes DIGIT bits per clock through a
// registered carry, WIDTH/DIGIT cycles per operation.
// Ports:
//   i_clk, i_rst_n           - clock, synchronous active-low reset
//   i_in_valid, o_in_ready   - operand handshake (i_a, i_b, i_cin, i_sub)
//   i_sub                    - 0: a+b+cin, 1: a-b (cin ignored)
//   o_out_valid, i_out_ready - result handshake (o_sum, o_cout, o_ovf)
//   o_cout                   - carry out of MSB; in subtract mode 1 = no borrow
//   o_ovf                    - two's-complement signed overflow
//   o_busy                   - operation in flight or result pending
module multicycle_adder
    import multicycle_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_busy
);

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("multicycle_adder: DIGIT must be in 1..WIDTH and divide WIDTH");
    end

    localparam int unsigned N  = num_digits(WIDTH, DIGIT);
    localparam int unsigned CW = cnt_width(WIDTH, DIGIT);

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;     // digit results shifted in from the top
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [DIGIT-1:0] w_dsum;
    logic             w_dcout;
    logic             w_dcmsb;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_last;

    multicycle_adder_digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .i_a     (r_a[DIGIT-1:0]),
        .i_b     (r_b[DIGIT-1:0]),
        .i_cin   (r_carry),
        .o_sum   (w_dsum),
        .o_cout  (w_dcout),
        .o_c_msb (w_dcmsb)
    );

    // Shift form keeps DIGIT == WIDTH legal (no zero-width slice).
    assign w_acc_next = (r_acc >> DIGIT) | (WIDTH'(w_dsum) << (WIDTH - DIGIT));
    assign w_last     = (r_cnt == CW'(N - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_in_valid) begin
                        r_a     <= i_a;
                        r_b     <= i_sub ? ~i_b : i_b;
                        r_carry <= i_sub | i_cin;
                        r_cnt   <= '0;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    r_acc   <= w_acc_next;
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_dcout;
                    r_cnt   <= r_cnt + CW'(1);
                    // Visible outputs only change when the final digit lands.
                    if (w_last) begin
                        r_sum   <= w_acc_next;
                        r_cout  <= w_dcout;
                        r_ovf   <= w_dcmsb ^ w_dcout;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    if (i_out_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_in_ready  = (r_state == StIdle);
    assign o_out_valid = (r_state == StDone);
    assign o_busy      = (r_state != StIdle);
    assign o_sum       = r_sum;
    assign o_cout      = r_cout;
    assign o_ovf       = r_ovf;

endmodule
